// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the sequential multiply/divide unit: opcodes, FSM states
// and the divide-by-zero quotient.
package muldiv_seq_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    WB   = 2'b10
  } state_e;

  typedef enum logic {
    CLS_MUL = 1'b0,
    CLS_DIV = 1'b1
  } opclass_e;

  localparam logic [15:0] DIV0_QUOT = 16'hFFFF;

  function automatic opclass_e op_class(input op_e op);
    return (op == OP_DIVU || op == OP_REMU) ? CLS_DIV : CLS_MUL;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: MSB-first shift-add for multiply,
// restoring shift-subtract for divide. Purely combinational.
module muldiv_step
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               in_bit,
  input  opclass_e           cls,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   trial;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quot_next;
  logic               ge;

  // Multiply: acc holds the full product; in_bit is the current multiplier bit.
  always_comb begin
    mul_next = (acc << 1);
    if (in_bit) begin
      mul_next = mul_next + {{WIDTH{1'b0}}, operand};
    end
  end

  // Divide: acc = {quotient, remainder}; in_bit is the next dividend bit.
  always_comb begin
    rem_sh    = {acc[WIDTH-1:0], in_bit};
    ge        = (rem_sh >= {1'b0, operand});
    trial     = rem_sh[WIDTH-1:0] - operand;
    rem_next  = ge ? trial : rem_sh[WIDTH-1:0];
    quot_next = {acc[2*WIDTH-2:WIDTH], ge};
  end

  always_comb begin
    acc_next = (cls == CLS_DIV) ? {quot_next, rem_next} : mul_next;
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 16-bit MUL/MULHU/DIVU/REMU unit: one bit per cycle, result returned
// as a single-cycle register-file write request.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [REGBITS-1:0] dst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic               regwrite,
  output logic [REGBITS-1:0] wa,
  output logic [WIDTH-1:0]   wd
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  state_e               state_reg, state_next;
  logic [CW-1:0]        cnt_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [2*WIDTH-1:0]   acc_next;
  op_e                  op_reg;
  logic [REGBITS-1:0]   dst_reg;
  logic [WIDTH-1:0]     a_reg, b_reg;
  logic [REGBITS-1:0]   wa_reg;
  logic [WIDTH-1:0]     wd_reg;

  logic [CW-1:0]        bit_idx;
  opclass_e             cls;
  logic                 step_bit;
  logic [WIDTH-1:0]     step_operand;
  logic                 last_iter;
  logic [WIDTH-1:0]     result;

  assign cls          = op_class(op_reg);
  assign bit_idx      = CNT_LAST - cnt_reg;
  assign step_bit     = (cls == CLS_DIV) ? a_reg[bit_idx] : b_reg[bit_idx];
  assign step_operand = (cls == CLS_DIV) ? b_reg : a_reg;
  assign last_iter    = (state_reg == RUN) && (cnt_reg == CNT_LAST);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_reg),
    .operand  (step_operand),
    .in_bit   (step_bit),
    .cls      (cls),
    .acc_next (acc_next)
  );

  // Selected from the final iteration's accumulator so wd is ready in WB.
  always_comb begin
    result = acc_next[WIDTH-1:0];
    case (op_reg)
      OP_MUL:   result = acc_next[WIDTH-1:0];
      OP_MULHU: result = acc_next[2*WIDTH-1:WIDTH];
      OP_DIVU:  result = (b_reg == '0) ? WIDTH'(DIV0_QUOT) : acc_next[2*WIDTH-1:WIDTH];
      OP_REMU:  result = acc_next[WIDTH-1:0];
      default:  result = acc_next[WIDTH-1:0];
    endcase
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    regwrite   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_next = WB;
      end
      WB: begin
        busy       = 1'b1;
        done       = 1'b1;
        regwrite   = (dst_reg != '0);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      op_reg    <= OP_MUL;
      dst_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      wa_reg    <= '0;
      wd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg  <= op_e'(op);
            dst_reg <= dst;
            a_reg   <= a;
            b_reg   <= b;
            cnt_reg <= '0;
            acc_reg <= '0;
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (last_iter) begin
            wd_reg <= result;
            wa_reg <= dst_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign wa = wa_reg;
  assign wd = wd_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: cycle-level reference model from plain arithmetic,
// directed literal cases, reset abort, and randomized traffic.
module tb_muldiv_seq;

  localparam int W  = 16;
  localparam int RB = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [RB-1:0] dst = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done, regwrite;
  logic [RB-1:0] wa;
  logic [W-1:0]  wd;

  int n_vec = 0;
  int n_bad = 0;

  muldiv_seq #(.WIDTH(W), .REGBITS(RB)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .dst      (dst),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .regwrite (regwrite),
    .wa       (wa),
    .wd       (wd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] x,
                                               input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (o)
      2'd0:    return p[W-1:0];
      2'd1:    return p[2*W-1:W];
      2'd2:    return (y == 0) ? 16'hFFFF : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Reference model: an op occupies W+1 cycles after acceptance; the last one is WB.
  int            m_left = 0;
  logic [W-1:0]  m_pend_wd = '0, m_held_wd = '0;
  logic [RB-1:0] m_pend_wa = '0, m_held_wa = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left    <= 0;
      m_pend_wd <= '0;
      m_pend_wa <= '0;
      m_held_wd <= '0;
      m_held_wa <= '0;
    end else if (m_left == 0) begin
      if (start) begin
        m_left    <= W + 1;
        m_pend_wd <= ref_result(op, a, b);
        m_pend_wa <= dst;
      end
    end else begin
      if (m_left == 1) begin
        m_held_wd <= m_pend_wd;
        m_held_wa <= m_pend_wa;
      end
      m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    chk("busy",     32'(busy),     32'(m_left > 0));
    chk("done",     32'(done),     32'(m_left == 1));
    chk("regwrite", 32'(regwrite), 32'((m_left == 1) && (m_pend_wa != 0)));
    chk("wa",       32'(wa),       32'((m_left == 1) ? m_pend_wa : m_held_wa));
    chk("wd",       32'(wd),       32'((m_left == 1) ? m_pend_wd : m_held_wd));
  end

  task automatic run_op(input string tag, input logic [1:0] o, input logic [RB-1:0] d,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] exp_wd, input bit repulse);
    int busy_n, done_n, done_at;
    logic [W-1:0]  wd_cap;
    logic [RB-1:0] wa_cap;
    logic          rw_cap;
    busy_n = 0; done_n = 0; done_at = 0; wd_cap = '0; wa_cap = '0; rw_cap = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; dst = d; a = x; b = y;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = repulse && (i == 3 || i == 16);
      op    = 2'($urandom);
      dst   = RB'($urandom);
      a     = W'($urandom);
      b     = W'($urandom);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = i;
        wd_cap  = wd;
        wa_cap  = wa;
        rw_cap  = regwrite;
      end
    end
    start = 1'b0;
    $display("%s: op=%0d dst=%0d a=0x%04h b=0x%04h -> wd=0x%04h wa=%0d rw=%0d",
             tag, o, d, x, y, wd_cap, wa_cap, rw_cap);
    chk({tag, ".wd"},      32'(wd_cap), 32'(exp_wd));
    chk({tag, ".wa"},      32'(wa_cap), 32'(d));
    chk({tag, ".rw"},      32'(rw_cap), 32'(d != 0));
    chk({tag, ".busy_n"},  32'(busy_n), 32'd17);
    chk({tag, ".done_n"},  32'(done_n), 32'd1);
    chk({tag, ".done_at"}, 32'(done_at), 32'd17);
  endtask

  initial begin
    int done_seen;
    #1 reset = 1'b0;
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.rw",   32'(regwrite), 32'd0);
    chk("rst.wa",   32'(wa), 32'd0);
    chk("rst.wd",   32'(wd), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    run_op("mul_1234",   2'd0, 5'd3,  16'h1234, 16'h0010, 16'h2340, 1'b0);
    run_op("mulhu_1234", 2'd1, 5'd3,  16'h1234, 16'h0010, 16'h0001, 1'b0);
    run_op("mul_ffff",   2'd0, 5'd9,  16'hFFFF, 16'hFFFF, 16'h0001, 1'b0);
    run_op("mulhu_ffff", 2'd1, 5'd9,  16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0);
    run_op("divu_100_7", 2'd2, 5'd12, 16'h0064, 16'h0007, 16'h000E, 1'b0);
    run_op("remu_100_7", 2'd3, 5'd12, 16'h0064, 16'h0007, 16'h0002, 1'b0);
    run_op("divu_by0",   2'd2, 5'd4,  16'h1234, 16'h0000, 16'hFFFF, 1'b0);
    run_op("remu_by0",   2'd3, 5'd4,  16'h1234, 16'h0000, 16'h1234, 1'b0);
    run_op("repulse",    2'd0, 5'd5,  16'h0101, 16'h0003, 16'h0303, 1'b1);
    run_op("dst_zero",   2'd2, 5'd0,  16'h00C8, 16'h000A, 16'h0014, 1'b0);
    run_op("wd_before_abort", 2'd0, 5'd6, 16'h00AB, 16'h0001, 16'h00AB, 1'b0);

    // Abort mid-RUN: outputs must clear without a clock edge, and no WB follows.
    @(negedge clk);
    start = 1'b1; op = 2'd0; dst = 5'd7; a = 16'h0011; b = 16'h0022;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    $display("abort: busy=%0d done=%0d rw=%0d wa=%0d wd=0x%04h", busy, done, regwrite, wa, wd);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.rw",   32'(regwrite), 32'd0);
    chk("abort.wa",   32'(wa), 32'd0);
    chk("abort.wd",   32'(wd), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    done_seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("abort.no_wb", 32'(done_seen), 32'd0);
    run_op("mul_3x5", 2'd0, 5'd1, 16'h0003, 16'h0005, 16'h000F, 1'b0);

    // Random traffic, including starts while busy; the model decides acceptance.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      op    = 2'($urandom);
      dst   = RB'($urandom);
      a     = ($urandom_range(0, 5) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = '1;
        default: b = W'($urandom);
      endcase
    end
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
